// File: rtl/mem_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_pkg: funct3 codes, dmem FSM state type and LOG2 helper
// Rev 1.0
// ------------------------------------------------------------------
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Ceiling log2; also sizes the TLB slot index, so both sides must agree.
  function automatic int LOG2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_lane_unit: store mask/merge, load extract/extend, error flag
// Rev 1.0
// ------------------------------------------------------------------
module dmem_lane_unit
  import mem_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_merged,
  output logic [31:0] o_ldata,
  output logic        o_err
);

  logic [3:0]  w_mask;
  logic [31:0] w_wrep;
  logic        w_misal;
  logic        w_illegal;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_illegal = 1'b0;
    w_misal   = 1'b0;
    w_mask    = 4'b0000;
    w_wrep    = i_wdata;
    case (i_funct3)
      F3_B: begin
        w_mask = 4'b0001 << i_lane;
        w_wrep = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        w_misal = i_lane[0];
        w_mask  = i_lane[1] ? 4'b1100 : 4'b0011;
        w_wrep  = {2{i_wdata[15:0]}};
      end
      F3_W: begin
        w_misal = |i_lane;
        w_mask  = 4'b1111;
      end
      F3_BU: w_illegal = i_we;
      F3_HU: begin
        w_illegal = i_we;
        w_misal   = i_lane[0];
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign o_err = w_illegal | w_misal;
  assign o_be  = (i_we && !o_err) ? w_mask : 4'b0000;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign o_merged[8*g +: 8] = o_be[g] ? w_wrep[8*g +: 8] : i_word[8*g +: 8];
  end

  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
  end

  assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_ldata = 32'd0;
    if (!i_we && !o_err) begin
      case (i_funct3)
        F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
        F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
        F3_W:    o_ldata = i_word;
        F3_BU:   o_ldata = {24'd0, w_byte};
        F3_HU:   o_ldata = {16'd0, w_half};
        default: o_ldata = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_slots.sv
`default_nettype none
// ------------------------------------------------------------------
// dmem_slots: word-organised data memory with byte/half/word access
// Rev 1.0
// ------------------------------------------------------------------
module dmem_slots
  import mem_pkg::*;
#(
  parameter int MEM_SLOTS_COUNT = 32,
  parameter int READ_LATENCY    = 1
) (
  input  logic                             _clk,
  input  logic                             _reset_n,
  input  logic                             _req_valid,
  output logic                             req_ready_,
  input  logic                             _req_we,
  input  logic [2:0]                       _req_funct3,
  input  logic [31:0]                      _req_vptr,
  input  logic [LOG2(MEM_SLOTS_COUNT)-1:0] _slot_n,
  input  logic [31:0]                      _req_wdata,
  output logic                             resp_valid_,
  input  logic                             _resp_ready,
  output logic [31:0]                      resp_rdata_,
  output logic                             resp_err_
);

  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

  dmem_state_t r_state;
  dmem_state_t w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_mem [MEM_SLOTS_COUNT];
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic [31:0] w_word;
  logic [3:0]  w_be;
  logic [31:0] w_merged;
  logic [31:0] w_ldata;
  logic        w_err;
  logic        w_unused_vptr;

  assign w_unused_vptr = ^_req_vptr[31:2];
  assign w_word        = r_mem[_slot_n];
  assign w_accept      = _req_valid & req_ready_;

  dmem_lane_unit u_lane (
    .i_we     (_req_we),
    .i_funct3 (_req_funct3),
    .i_lane   (_req_vptr[1:0]),
    .i_wdata  (_req_wdata),
    .i_word   (w_word),
    .o_be     (w_be),
    .o_merged (w_merged),
    .o_ldata  (w_ldata),
    .o_err    (w_err)
  );

  always_ff @(posedge _clk) begin
    if (!_reset_n) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = WAIT;
      WAIT:    if (r_cnt == 4'd0) w_next = RESP;
      RESP:    if (_resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Ready is also gated by reset so nothing is accepted while it is held.
  always_comb begin
    req_ready_  = 1'b0;
    resp_valid_ = 1'b0;
    case (r_state)
      IDLE:    req_ready_  = _reset_n;
      RESP:    resp_valid_ = 1'b1;
      default: ;
    endcase
  end

  // Load result is resolved on the accept edge and simply held until handshake.
  always_ff @(posedge _clk) begin
    if (!_reset_n) begin
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= LAT_INIT;
      r_rdata <= w_ldata;
      r_err   <= w_err;
    end else if (r_state == WAIT && r_cnt != 4'd0) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge _clk) begin
    if (w_accept && (|w_be)) r_mem[_slot_n] <= w_merged;
  end

  assign resp_rdata_ = r_rdata;
  assign resp_err_   = r_err;

endmodule
`default_nettype wire
